// File: rtl/keypad_scan.sv
// Scanned 4x4 active-low keypad reader: rotates one column low, samples rows per column,
// debounces whole-matrix frames and emits one-cycle press/release events with a key code.
module keypad_scan #(
   parameter int SCAN_DIV = 16,
   parameter int DEBOUNCE = 4
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic [3:0] iRow,
   output logic [3:0] oCol,
   output logic [3:0] oKey,
   output logic       oValid,
   output logic       oRelease,
   output logic       oHeld
);

   // state   | meaning
   // IDLE    | no committed key; waiting for a stable single-key frame
   // PRESSED | a key press was committed; waiting for a stable empty frame
   typedef enum logic {
      IDLE    = 1'b0,
      PRESSED = 1'b1
   } stateT;

   localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE);

   logic [3:0]          rRowMeta;
   logic [3:0]          rRowSync;
   logic [SCAN_DIV-1:0] rCnt;
   logic [3:0]          rColSel;
   logic [11:0]         rFrame;
   logic [15:0]         rLastFrame;
   logic [3:0]          rCount;
   stateT               rState;
   stateT               nextState;

   logic                tick;
   logic                frameDone;
   logic [15:0]         frameNow;
   logic [4:0]          bitCnt;
   logic [3:0]          keyCode;
   logic                isEmpty;
   logic                isSingle;
   logic                stable;
   logic                validNext;
   logic                releaseNext;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         rRowMeta <= 4'b1111;
         rRowSync <= 4'b1111;
      end else begin
         rRowMeta <= iRow;
         rRowSync <= rRowMeta;
      end
   end

   assign tick      = &rCnt;
   assign frameDone = tick && rColSel[3];

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         rCnt    <= '0;
         rColSel <= 4'b0001;
      end else begin
         rCnt <= rCnt + {{(SCAN_DIV-1){1'b0}}, 1'b1};
         if (tick) begin
            rColSel <= {rColSel[2:0], rColSel[3]};
         end
      end
   end

   assign oCol = ~rColSel;

   // Columns 0..2 are stored; column 3 is taken straight from the synchronizer
   // on the completing tick so the whole frame is available in that cycle.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         rFrame <= '0;
      end else if (tick) begin
         if (rColSel[0]) rFrame[3:0]  <= ~rRowSync;
         if (rColSel[1]) rFrame[7:4]  <= ~rRowSync;
         if (rColSel[2]) rFrame[11:8] <= ~rRowSync;
      end
   end

   assign frameNow = {~rRowSync, rFrame};

   always_comb begin
      bitCnt  = '0;
      keyCode = '0;
      for (int i = 0; i < 16; i++) begin
         bitCnt = bitCnt + {4'b0000, frameNow[i]};
         if (frameNow[i]) keyCode = 4'(i);
      end
      isEmpty  = (frameNow == 16'h0000);
      isSingle = (bitCnt == 5'd1);
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         rLastFrame <= '0;
         rCount     <= '0;
      end else if (frameDone) begin
         if (frameNow != rLastFrame) begin
            rLastFrame <= frameNow;
            rCount     <= 4'd1;
         end else if (rCount < DEB_MAX) begin
            rCount <= rCount + 4'd1;
         end
      end
   end

   // Stable only on the completion where the count reaches the threshold,
   // so a long-held frame is acted on once.
   always_comb begin
      stable = 1'b0;
      if (frameDone) begin
         if (frameNow != rLastFrame) begin
            stable = (DEB_MAX == 4'd1);
         end else begin
            stable = (rCount < DEB_MAX) && ((rCount + 4'd1) == DEB_MAX);
         end
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         rState <= IDLE;
      end else begin
         rState <= nextState;
      end
   end

   always_comb begin
      nextState = rState;
      if (stable) begin
         case (rState)
            IDLE:    if (isSingle) nextState = PRESSED;
            PRESSED: if (isEmpty)  nextState = IDLE;
            default: nextState = IDLE;
         endcase
      end
   end

   always_comb begin
      validNext   = stable && (rState == IDLE) && isSingle;
      releaseNext = stable && (rState == PRESSED) && isEmpty;
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oKey     <= '0;
         oValid   <= 1'b0;
         oRelease <= 1'b0;
      end else begin
         oValid   <= validNext;
         oRelease <= releaseNext;
         if (validNext) oKey <= keyCode;
      end
   end

   assign oHeld = (rState == PRESSED);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a matrix model drives iRow from oCol and a key set,
// event counters track oValid/oRelease pulses, and expected values are hand-computed.
module tb_keypad_scan;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic [3:0]  iRow;
   logic [3:0]  oCol;
   logic [3:0]  oKey;
   logic        oValid;
   logic        oRelease;
   logic        oHeld;

   logic [15:0] keysDown;
   int          nCompared  = 0;
   int          nMismatch  = 0;
   int          validCnt   = 0;
   int          releaseCnt = 0;
   logic [3:0]  lastKey    = 4'd0;

   keypad_scan #(.SCAN_DIV(2), .DEBOUNCE(4)) dut (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .iRow     (iRow),
      .oCol     (oCol),
      .oKey     (oKey),
      .oValid   (oValid),
      .oRelease (oRelease),
      .oHeld    (oHeld)
   );

   always #5 iCLK = ~iCLK;

   // Row r is pulled low when key (c,r) is down and column c is driven low.
   always_comb begin
      iRow = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (keysDown[c*4+r] && !oCol[c]) iRow[r] = 1'b0;
         end
      end
   end

   task automatic chkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatch++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge iCLK) begin
      if (oValid) begin
         validCnt++;
         lastKey = oKey;
         chkEq("heldWithValid", {31'd0, oHeld}, 32'd1);
      end
      if (oRelease) begin
         releaseCnt++;
         chkEq("heldWithRelease", {31'd0, oHeld}, 32'd0);
      end
      if (oValid || oRelease) begin
         chkEq("validReleaseExcl", {31'd0, oValid & oRelease}, 32'd0);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   // Returns at the first negedge of a new frame (column 0 just driven).
   task automatic waitFrameStart();
      logic [3:0] prevCol;
      logic       timedOut;
      prevCol  = oCol;
      timedOut = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge iCLK);
         if (prevCol == 4'b0111 && oCol == 4'b1110) begin
            timedOut = 1'b0;
            break;
         end
         prevCol = oCol;
      end
      chkEq("frameWait", {31'd0, timedOut}, 32'd0);
   endtask

   task automatic settle(input int nFrames);
      repeat (nFrames) waitFrameStart();
      cycles(2);
   endtask

   task automatic applyKeys(input logic [15:0] k);
      waitFrameStart();
      keysDown = k;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] expCol;
      iRST     = 1'b1;
      keysDown = 16'h0000;
      cycles(3);
      chkEq("rstCol",     {28'd0, oCol}, 32'd14);
      chkEq("rstKey",     {28'd0, oKey}, 32'd0);
      chkEq("rstValid",   {31'd0, oValid}, 32'd0);
      chkEq("rstRelease", {31'd0, oRelease}, 32'd0);
      chkEq("rstHeld",    {31'd0, oHeld}, 32'd0);
      iRST = 1'b0;

      // Column rotation: four cycles per column starting at column 0.
      for (int k = 0; k < 40; k++) begin
         expCol = 4'b0001 << ((k / 4) % 4);
         expCol = ~expCol;
         chkEq("colRot", {28'd0, oCol}, {28'd0, expCol});
         @(negedge iCLK);
      end

      // Clean press of key 9 (col 2, row 1), held, then released.
      applyKeys(16'h0200);
      settle(3);
      chkEq("press9Early", validCnt, 0);
      settle(1);
      chkEq("press9Valid", validCnt, 1);
      chkEq("press9Key",   {28'd0, lastKey}, 32'd9);
      chkEq("press9Held",  {31'd0, oHeld}, 32'd1);
      settle(6);
      chkEq("press9NoRepeat", validCnt, 1);
      applyKeys(16'h0000);
      settle(3);
      chkEq("rel9Early", releaseCnt, 0);
      settle(1);
      chkEq("rel9Release", releaseCnt, 1);
      chkEq("rel9Held",    {31'd0, oHeld}, 32'd0);
      chkEq("rel9KeyKept", {28'd0, oKey}, 32'd9);

      // Bounce on key 5: pressed, open, pressed, then steady.
      applyKeys(16'h0020);
      waitFrameStart();
      keysDown = 16'h0000;
      waitFrameStart();
      keysDown = 16'h0020;
      settle(3);
      chkEq("bounceNoEvent", validCnt, 1);
      settle(1);
      chkEq("bounceValid", validCnt, 2);
      chkEq("bounceKey",   {28'd0, lastKey}, 32'd5);
      applyKeys(16'h0000);
      settle(5);
      chkEq("bounceRelease", releaseCnt, 2);

      // Two keys (0,0) and (3,3): multi frame is ignored until (0,0) drops.
      applyKeys(16'h8001);
      settle(6);
      chkEq("multiNoValid", validCnt, 2);
      applyKeys(16'h8000);
      settle(3);
      chkEq("dropEarly", validCnt, 2);
      settle(1);
      chkEq("dropValid", validCnt, 3);
      chkEq("dropKey",   {28'd0, lastKey}, 32'd15);
      applyKeys(16'h0000);
      settle(5);
      chkEq("dropRelease", releaseCnt, 3);

      // Key 3 held, key 12 added: no rollover; one release for both.
      applyKeys(16'h0008);
      settle(5);
      chkEq("hold3Valid", validCnt, 4);
      chkEq("hold3Key",   {28'd0, lastKey}, 32'd3);
      applyKeys(16'h1008);
      settle(6);
      chkEq("rolloverNoValid", validCnt, 4);
      chkEq("rolloverHeld",    {31'd0, oHeld}, 32'd1);
      applyKeys(16'h0000);
      settle(6);
      chkEq("rolloverRelease", releaseCnt, 4);
      chkEq("rolloverValid",   validCnt, 4);

      // Reset in the third debounce frame of a press of key 6.
      applyKeys(16'h0040);
      repeat (2) waitFrameStart();
      cycles(5);
      iRST = 1'b1;
      #1;
      chkEq("midRstCol",     {28'd0, oCol}, 32'd14);
      chkEq("midRstKey",     {28'd0, oKey}, 32'd0);
      chkEq("midRstValid",   {31'd0, oValid}, 32'd0);
      chkEq("midRstRelease", {31'd0, oRelease}, 32'd0);
      chkEq("midRstHeld",    {31'd0, oHeld}, 32'd0);
      cycles(3);
      iRST = 1'b0;
      chkEq("midRstNoValid", validCnt, 4);
      settle(3);
      chkEq("postRstEarly", validCnt, 4);
      settle(1);
      chkEq("postRstValid", validCnt, 5);
      chkEq("postRstKey",   {28'd0, lastKey}, 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanned 4x4 matrix keypad reader: the input-side counterpart of the multiplexed seven-segment output path. It drives one active-low column at a time from a free-running divider and samples the active-low row lines once per column. It debounces whole-matrix snapshots and emits one-cycle press and release events with a 4-bit key code. Downstream logic (Nios II PIO or a digit-entry register feeding the display path) consumes `oKey`/`oValid`.

## Interface
- `SCAN_DIV`, 16: divider width; column dwell = 2^SCAN_DIV cycles.
- `DEBOUNCE`, 4: consecutive identical full-matrix frames required to commit a change (1..15).

- `iCLK`  in  1  system clock; all logic rising-edge.
- `iRST`  in  1  reset, asynchronous, active-high.
- `iRow`  in  4  row sense lines, active-low (pulled up), asynchronous to iCLK.
- `oCol`  out 4  column drive, active-low, exactly one bit low at all times.
- `oKey`  out 4  key code {col[1:0], row[1:0]} of last committed press.
- `oValid` out 1  one-cycle pulse: new key press committed.
- `oRelease` out 1  one-cycle pulse: release of the held key committed.
- `oHeld` out 1  level: a committed key is currently held.

## Operation
- `iRow` passes through a 2-flop synchronizer (reset value 4'b1111); all row use is on the synchronized value.
- Divider `rCnt` (SCAN_DIV bits) increments every cycle and wraps. Tick = cycle where `rCnt` is all ones.
- Column one-hot `rColSel` rotates 0001->0010->0100->1000->0001 on each tick; `oCol = ~rColSel`.
- On each tick, capture the synchronized rows into frame bits [col*4+3 : col*4], inverted so 1 = pressed.
- Tick at column 3 completes a 16-bit frame. Classify it as empty, single (exactly one bit, code = bit index), or multi (two or more bits).
- Debounce on frame completion:
  - If frame != `rLastFrame`: `rLastFrame` <= frame, `rCount` <= 1.
  - Else `rCount` <= min(`rCount`+1, DEBOUNCE).
  - Frame is "stable" on the completion where `rCount` becomes DEBOUNCE from a lower value; this includes the reset-to-1 case when DEBOUNCE=1.
- FSM, evaluated only on stable frames:
  - IDLE + single: `oKey` <= code, pulse `oValid`, `oHeld` <= 1, go to PRESSED.
  - IDLE + empty or multi: no action.
  - PRESSED + empty: pulse `oRelease`, `oHeld` <= 0, go to IDLE.
  - PRESSED + single (any code) or multi: no action. No rollover and no auto-repeat; a full release is required before the next press.
- `oKey` holds its value until the next committed press; it is not cleared on release.
- `iRST` asserted mid-scan or mid-debounce abandons the partial frame; no event is emitted.

## Timing
- Reset values: `oCol` = 4'b1110, `oKey` = 0, `oValid` = 0, `oRelease` = 0, `oHeld` = 0, `rCnt` = 0, `rLastFrame` = 0, `rCount` = 0, state IDLE. All take effect immediately on `iRST` high, independent of the clock.
- First column change occurs 2^SCAN_DIV cycles after reset release; a frame takes 4*2^SCAN_DIV cycles.
- Rows are sampled at the end of a column dwell. The dwell must be at least 3 cycles (SCAN_DIV >= 2) so the synchronizer settles.
- `oValid`/`oRelease` are registered: high for exactly the one cycle after the completing column-3 tick, then low.
- Press latency from the first clean frame is DEBOUNCE frames. Release latency is the same.
- `oHeld` rises in the same cycle as `oValid` and falls in the same cycle as `oRelease`.
- `oValid` and `oRelease` are never high together.

## Test plan
Bench settings: SCAN_DIV=2, DEBOUNCE=4. The keypad model pulls `iRow[r]` low iff key (c,r) is pressed and `oCol[c]`=0.

- Column rotation: run 40 cycles after reset -> `oCol` = 1110,1101,1011,0111, repeating, 4 cycles each.
- Clean press (col 2, row 1) held 10 frames -> one `oValid` with `oKey` = 9 after the 4th identical frame. `oHeld` = 1, no repeat. Release -> one `oRelease` after 4 empty frames, `oKey` stays 9.
- Bounce: key 5 toggling every frame for 3 frames, then steady -> no event during the toggling; exactly one `oValid` (`oKey` = 5) after 4 steady frames.
- Two keys (0,0) and (3,3) pressed -> no `oValid`. Drop (0,0) -> `oValid` with `oKey` = 15 after 4 frames.
- Key 3 held, then key 12 added -> no second `oValid`. Release both -> a single `oRelease`.
- Assert `iRST` during the 3rd debounce frame of a press -> outputs return to their reset values at once and no `oValid` appears. After release of reset with the key still held -> `oValid` (same code) 4 full frames later.
